pixel_row_readout: RTL and testbench
====================================

Name: pixel_row_readout

Overview:
- Read-side sequencer for the pixel array's shared tristate DATA bus.
- After the convert phase, it selects one row at a time with a one-hot row select and asserts read_en. Read_en releases the bus so the pixel array can drive it.
- It captures each row word into a small row FIFO, then serializes the FIFO contents into an 8-bit pixel stream using a valid/ready handshake with frame and line markers.
- It sits between the array control FSM (which pulses start) and downstream pixel storage or output.

Parameters:
- ROWS, 2, number of pixel rows; width of row_sel.
- COLUMNS, 2, pixels per row; data_in is 8*COLUMNS bits.
- FIFO_DEPTH, 2, row words buffered; must be >=1.

Ports:
- clk  input  1  clock; all sequential logic on posedge.
- reset  input  1  asynchronous, active-high.
- start  input  1  single-cycle pulse that begins a frame readout; ignored while busy.
- busy  output  1  high whenever the FSM is not IDLE.
- done  output  1  one-cycle pulse when the last pixel of the frame has been accepted downstream.
- read_en  output  1  high while a row is selected; the bus driver tristates DATA when high.
- row_sel  output  ROWS  one-hot row select; bit r selects row r.
- data_in  input  8*COLUMNS  DATA bus as driven by the selected row.
- pix_valid  output  1  pix_data is valid.
- pix_ready  input  1  downstream accepts the pixel when valid && ready at posedge.
- pix_data  output  8  pixel value.
- pix_sof  output  1  qualifies the first pixel of the frame (row 0, column 0).
- pix_eol  output  1  qualifies the last pixel of a row (column COLUMNS-1).
- pix_eof  output  1  qualifies the last pixel of the frame; always coincides with pix_eol.

Behaviour:
- Reset (async): state IDLE, FIFO emptied, row/column counters 0. All outputs are 0, including row_sel and read_en, immediately and without waiting for a clock edge.
- All outputs are registered.
- FSM states: IDLE, SELECT, SAMPLE, WAIT_SPACE, DRAIN.
- IDLE: on start, go to SELECT with row=0. The FIFO is always empty in IDLE.
- SELECT: row_sel=1<<row, read_en=1. Lasts one cycle, then go to SAMPLE. This cycle gives the bus one cycle to settle.
- SAMPLE: row_sel and read_en are held. At the end of this cycle, data_in is written into the FIFO. Next state:
  - row==ROWS-1 -> DRAIN.
  - else FIFO full after this push -> WAIT_SPACE.
  - else -> SELECT with row+1.
- WAIT_SPACE: row_sel=0, read_en=0. When FIFO count < FIFO_DEPTH, go to SELECT with row+1.
- DRAIN: row_sel=0, read_en=0. When the FIFO is empty and the serializer has no pending pixel, pulse done for one cycle and go to IDLE.
- Timing: start sampled at edge N gives:
  - row_sel and read_en high for the cycles after edges N and N+1;
  - row 0 captured at edge N+2;
  - pix_valid high at the earliest after edge N+3.
- Unstalled frame: row_sel is never active on two rows in one cycle, and rows are strictly ascending.
- Serializer:
  - Pops one row word when it is idle or its last pixel is being accepted. Back-to-back rows therefore have no bubble.
  - Emits column 0 first: pix_data = word[8c+7:8c] for column c.
  - Once pix_valid is high, pix_data and the markers stay stable until the pixel is accepted.
  - pix_valid is never withdrawn without acceptance.
- FIFO write and pop in the same cycle are allowed; the count is unchanged.
- A push is never issued when the FIFO is full; the FSM guarantees this.
- start while busy is ignored and has no side effects.
- done and the eof acceptance: done asserts the cycle after the eof pixel is accepted. If start arrives in that same done cycle, it is ignored because busy is still high.
- Reset mid-frame: readout aborts, buffered pixels are discarded, and no done is pulsed. The next start begins a fresh frame at row 0 with sof.
- Only data_in present during SAMPLE is captured. Bus values during other states are ignored.

Test Plan:
- Nominal, ROWS=2, COLUMNS=2, pix_ready=1: row0 drives 16'hB2A1, row1 drives 16'hD4C3 -> pix_data sequence:
  - A1 (sof)
  - B2 (eol)
  - C3
  - D4 (eol, eof)

  Also required: row_sel 01 for 2 cycles, then 10 for 2 cycles; done pulses once; busy then drops.
- Backpressure, ROWS=4, FIFO_DEPTH=1, pix_ready=0 for 20 cycles -> FSM parks in WAIT_SPACE with read_en=0. pix_data holds row0 col0 stable. When ready rises, all 8 pixels arrive in order, then done.
- Random pix_ready toggling over 10 frames -> no lost or duplicated pixels; sof and eof exactly once per frame; read_en high only together with a one-hot row_sel.
- start pulsed again during readout and in the done cycle -> ignored; the frame completes normally; exactly one done per accepted start.
- Reset asserted mid-row (in SAMPLE of row 1) -> row_sel=0, read_en=0, pix_valid=0 immediately. The next start yields a full frame beginning with sof on row 0.
- Boundary, ROWS=1, COLUMNS=1: data_in=8'h5A -> a single pixel 5A with sof, eol and eof all high, then done.

Source files
------------

// File: rtl/pixel_row_readout.sv
// Read-side sequencer for the pixel array DATA bus: selects rows one at a time,
// buffers each row word in a small FIFO and serializes it as an 8-bit pixel stream.
module pixel_row_readout #(
    parameter int ROWS       = 2,
    parameter int COLUMNS    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 read_en,
    output logic [ROWS-1:0]      row_sel,
    input  logic [8*COLUMNS-1:0] data_in,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [7:0]           pix_data,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 pix_eof
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = 8 * COLUMNS;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLUMNS - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SELECT, SAMPLE, WAIT_SPACE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic            read_en_q, read_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [WW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;

    logic [WW-1:0]   word_q, word_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   cur_row_q, cur_row_d, pop_row_q, pop_row_d;
    logic            pix_valid_q, pix_valid_d;
    logic [7:0]      pix_data_q, pix_data_d;
    logic            pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d, pix_eof_q, pix_eof_d;

    logic push, pop, accept, last_accept;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        accept      = pix_valid_q && pix_ready;
        last_accept = accept && (col_q == LAST_COL);
        push        = (state_q == SAMPLE);
        pop         = (count_q != '0) && (!pix_valid_q || last_accept);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + NW'(1);
        if (pop && !push) count_d = count_q - NW'(1);

        word_d      = word_q;
        col_d       = col_q;
        cur_row_d   = cur_row_q;
        pop_row_d   = pop_row_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_sof_d   = pix_sof_q;
        pix_eol_d   = pix_eol_q;
        pix_eof_d   = pix_eof_q;
        // Popping on the last-column handshake keeps consecutive rows bubble-free.
        if (pop) begin
            word_d      = fifo_mem[rd_ptr_q];
            col_d       = '0;
            cur_row_d   = pop_row_q;
            pop_row_d   = (pop_row_q == LAST_ROW) ? '0 : pop_row_q + RW'(1);
            pix_valid_d = 1'b1;
            pix_data_d  = word_d[7:0];
            pix_sof_d   = (pop_row_q == '0);
            pix_eol_d   = (LAST_COL == '0);
            pix_eof_d   = (LAST_COL == '0) && (pop_row_q == LAST_ROW);
        end else if (last_accept) begin
            pix_valid_d = 1'b0;
            pix_sof_d   = 1'b0;
            pix_eol_d   = 1'b0;
            pix_eof_d   = 1'b0;
        end else if (accept) begin
            col_d      = col_q + CW'(1);
            pix_data_d = word_q[8*col_d +: 8];
            pix_sof_d  = 1'b0;
            pix_eol_d  = (col_d == LAST_COL);
            pix_eof_d  = (col_d == LAST_COL) && (cur_row_q == LAST_ROW);
        end

        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SELECT;
                    row_d   = '0;
                end
            end
            SELECT: state_d = SAMPLE;
            SAMPLE: begin
                if (row_q == LAST_ROW) begin
                    state_d = DRAIN;
                end else if (count_d == DEPTH_N) begin
                    state_d = WAIT_SPACE;
                end else begin
                    state_d = SELECT;
                    row_d   = row_q + RW'(1);
                end
            end
            WAIT_SPACE: begin
                if (count_q < DEPTH_N) begin
                    state_d = SELECT;
                    row_d   = row_q + RW'(1);
                end
            end
            DRAIN: begin
                if (count_q == '0 && !pix_valid_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        read_en_d = (state_d == SELECT) || (state_d == SAMPLE);
        row_sel_d = read_en_d ? (ROWS'(1) << row_d) : '0;
        busy_d    = (state_d != IDLE);
        done_d    = last_accept && pix_eof_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            row_sel_q   <= '0;
            read_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            word_q      <= '0;
            col_q       <= '0;
            cur_row_q   <= '0;
            pop_row_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            row_sel_q   <= row_sel_d;
            read_en_q   <= read_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            word_q      <= word_d;
            col_q       <= col_d;
            cur_row_q   <= cur_row_d;
            pop_row_q   <= pop_row_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_sof_q   <= pix_sof_d;
            pix_eol_q   <= pix_eol_d;
            pix_eof_q   <= pix_eof_d;
        end
    end

    // NOTE: the FIFO storage has no reset; count_q alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= data_in;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign read_en   = read_en_q;
    assign row_sel   = row_sel_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_sof   = pix_sof_q;
    assign pix_eol   = pix_eol_q;
    assign pix_eof   = pix_eof_q;
endmodule

// File: tb/tb_pixel_row_readout.sv
// Directed bench for pixel_row_readout: three instances cover the 2x2 nominal,
// the 4-row depth-1 backpressure and the 1x1 boundary configurations.
module tb_pixel_row_readout;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instance A: 2 rows x 2 columns, depth 2
    logic        start_a, busy_a, done_a, read_en_a, pix_valid_a, pix_ready_a;
    logic        pix_sof_a, pix_eol_a, pix_eof_a;
    logic [1:0]  row_sel_a;
    logic [15:0] data_a;
    logic [7:0]  pix_data_a;
    logic [15:0] rows_a [2];

    // Instance B: 4 rows x 2 columns, depth 1
    logic        start_b, busy_b, done_b, read_en_b, pix_valid_b, pix_ready_b;
    logic        pix_sof_b, pix_eol_b, pix_eof_b;
    logic [3:0]  row_sel_b;
    logic [15:0] data_b;
    logic [7:0]  pix_data_b;

    // Instance C: 1 row x 1 column, depth 1
    logic        start_c, busy_c, done_c, read_en_c, pix_valid_c, pix_ready_c;
    logic        pix_sof_c, pix_eol_c, pix_eof_c;
    logic [0:0]  row_sel_c;
    logic [7:0]  data_c;
    logic [7:0]  pix_data_c;

    pixel_row_readout #(.ROWS(2), .COLUMNS(2), .FIFO_DEPTH(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .read_en(read_en_a), .row_sel(row_sel_a), .data_in(data_a),
        .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .pix_data(pix_data_a),
        .pix_sof(pix_sof_a), .pix_eol(pix_eol_a), .pix_eof(pix_eof_a));

    pixel_row_readout #(.ROWS(4), .COLUMNS(2), .FIFO_DEPTH(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .read_en(read_en_b), .row_sel(row_sel_b), .data_in(data_b),
        .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_data(pix_data_b),
        .pix_sof(pix_sof_b), .pix_eol(pix_eol_b), .pix_eof(pix_eof_b));

    pixel_row_readout #(.ROWS(1), .COLUMNS(1), .FIFO_DEPTH(1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
        .read_en(read_en_c), .row_sel(row_sel_c), .data_in(data_c),
        .pix_valid(pix_valid_c), .pix_ready(pix_ready_c), .pix_data(pix_data_c),
        .pix_sof(pix_sof_c), .pix_eol(pix_eol_c), .pix_eof(pix_eof_c));

    // Pixel array model: the selected row drives its word, otherwise junk
    always_comb begin
        data_a = 16'hEEEE;
        if (read_en_a && row_sel_a == 2'b01) data_a = rows_a[0];
        if (read_en_a && row_sel_a == 2'b10) data_a = rows_a[1];
    end
    always_comb begin
        data_b = 16'hEEEE;
        for (int r = 0; r < 4; r++)
            if (read_en_b && row_sel_b[r]) data_b = {8'(8'h11 + 2*r), 8'(8'h10 + 2*r)};
    end
    assign data_c = read_en_c ? 8'h5A : 8'h00;

    // Monitors: entries are {sof, eol, eof, data}
    logic [10:0] got_a[$], got_b[$], got_c[$];
    logic [1:0]  rs_log_a[$];
    int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
    int sel_bad = 0, unstable_a = 0, unstable_b = 0;
    bit hold_a = 0, hold_b = 0;
    logic [10:0] prev_a, prev_b;

    always @(negedge clk) begin
        if (pix_valid_a && pix_ready_a) got_a.push_back({pix_sof_a, pix_eol_a, pix_eof_a, pix_data_a});
        if (done_a) done_cnt_a++;
        if (row_sel_a != 2'b00) rs_log_a.push_back(row_sel_a);
        if ((read_en_a && !$onehot(row_sel_a)) || (!read_en_a && row_sel_a != 2'b00)) sel_bad++;
        if (hold_a && {pix_sof_a, pix_eol_a, pix_eof_a, pix_data_a} != prev_a) unstable_a++;
        hold_a = pix_valid_a && !pix_ready_a && !reset;
        prev_a = {pix_sof_a, pix_eol_a, pix_eof_a, pix_data_a};

        if (pix_valid_b && pix_ready_b) got_b.push_back({pix_sof_b, pix_eol_b, pix_eof_b, pix_data_b});
        if (done_b) done_cnt_b++;
        if ((read_en_b && !$onehot(row_sel_b)) || (!read_en_b && row_sel_b != 4'b0)) sel_bad++;
        if (hold_b && {pix_sof_b, pix_eol_b, pix_eof_b, pix_data_b} != prev_b) unstable_b++;
        hold_b = pix_valid_b && !pix_ready_b && !reset;
        prev_b = {pix_sof_b, pix_eol_b, pix_eof_b, pix_data_b};

        if (pix_valid_c && pix_ready_c) got_c.push_back({pix_sof_c, pix_eol_c, pix_eof_c, pix_data_c});
        if (done_c) done_cnt_c++;
    end

    task automatic clear_logs();
        @(posedge clk); #1;
        got_a.delete(); got_b.delete(); got_c.delete(); rs_log_a.delete();
        done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0;
    endtask

    // Returns one ns after the edge that samples start
    task automatic pulse_start(input int inst);
        @(posedge clk); #1;
        if (inst == 0) start_a = 1'b1;
        if (inst == 1) start_b = 1'b1;
        if (inst == 2) start_c = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Returns at the falling edge inside the done cycle, or counts a failure on timeout
    task automatic wait_done(input int inst, input int budget, input bit rnd, input string tag);
        bit seen = 0;
        int n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if ((inst == 0 && done_a) || (inst == 1 && done_b) || (inst == 2 && done_c)) begin
                seen = 1;
            end else begin
                @(posedge clk); #1;
                if (rnd) pix_ready_a = 1'($urandom_range(0, 1));
            end
            n++;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_frame_a(input string tag, input logic [15:0] w0, input logic [15:0] w1);
        logic [10:0] exp [4];
        int bad = 0;
        exp[0] = {3'b100, w0[7:0]};
        exp[1] = {3'b010, w0[15:8]};
        exp[2] = {3'b000, w1[7:0]};
        exp[3] = {3'b011, w1[15:8]};
        check({tag, "_count"}, 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i >= got_a.size() || got_a[i] !== exp[i]) bad++;
        check({tag, "_pixels"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [10:0] exp_b;
        reset = 1'b1;
        start_a = 0; start_b = 0; start_c = 0;
        pix_ready_a = 0; pix_ready_b = 0; pix_ready_c = 0;
        rows_a[0] = 16'h0; rows_a[1] = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_a", {busy_a, done_a, read_en_a, row_sel_a, pix_valid_a, pix_data_a, pix_sof_a, pix_eol_a, pix_eof_a}, 0);
        check("rst_b", {busy_b, done_b, read_en_b, row_sel_b, pix_valid_b, pix_data_b}, 0);
        check("rst_c", {busy_c, done_c, read_en_c, row_sel_c, pix_valid_c, pix_data_c}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Nominal 2x2 frame
        rows_a[0] = 16'hB2A1; rows_a[1] = 16'hD4C3;
        pix_ready_a = 1'b1;
        clear_logs();
        pulse_start(0);
        @(negedge clk);
        check("nom_first_sel", {busy_a, read_en_a, row_sel_a, pix_valid_a}, {1'b1, 1'b1, 2'b01, 1'b0});
        wait_done(0, 50, 0, "nom_done_seen");
        check_frame_a("nom", 16'hB2A1, 16'hD4C3);
        check("nom_rowsel_len", 32'(rs_log_a.size()), 32'd4);
        if (rs_log_a.size() == 4)
            check("nom_rowsel_seq", {rs_log_a[0], rs_log_a[1], rs_log_a[2], rs_log_a[3]}, 8'b01_01_10_10);
        repeat (2) @(negedge clk);
        check("nom_done_once", 32'(done_cnt_a), 32'd1);
        check("nom_idle_after", {busy_a, done_a}, 2'b00);

        // Backpressure: 4 rows, depth 1, stalled for 20 cycles
        clear_logs();
        pulse_start(1);
        repeat (20) @(negedge clk);
        check("bp_parked", {busy_b, read_en_b, row_sel_b, pix_valid_b, pix_sof_b, pix_eol_b, pix_data_b},
              {1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h10});
        check("bp_none_taken", 32'(got_b.size()), 32'd0);
        @(posedge clk); #1 pix_ready_b = 1'b1;
        wait_done(1, 100, 0, "bp_done_seen");
        check("bp_count", 32'(got_b.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            exp_b = {(i == 0), (i % 2 == 1), (i == 7), 8'(8'h10 + i)};
            check($sformatf("bp_px%0d", i), (i < got_b.size()) ? 32'(got_b[i]) : 32'hFFFF_FFFF, 32'(exp_b));
        end
        check("bp_stable", 32'(unstable_b), 32'd0);

        // Boundary 1x1
        pix_ready_c = 1'b1;
        clear_logs();
        pulse_start(2);
        wait_done(2, 30, 0, "one_done_seen");
        check("one_count", 32'(got_c.size()), 32'd1);
        if (got_c.size() == 1) check("one_px", 32'(got_c[0]), {21'd0, 3'b111, 8'h5A});
        repeat (2) @(negedge clk);
        check("one_done_once", 32'(done_cnt_c), 32'd1);

        // Start pulsed during readout and in the done cycle
        rows_a[0] = 16'h2211; rows_a[1] = 16'h4433;
        clear_logs();
        pulse_start(0);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done(0, 50, 0, "ign_done_seen");
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (10) @(negedge clk);
        check_frame_a("ign", 16'h2211, 16'h4433);
        check("ign_done_once", 32'(done_cnt_a), 32'd1);
        check("ign_no_restart", {busy_a, 8'(rs_log_a.size())}, {1'b0, 8'd4});

        // Ten frames with random ready
        for (int f = 0; f < 10; f++) begin
            rows_a[0] = 16'($urandom); rows_a[1] = 16'($urandom);
            clear_logs();
            pulse_start(0);
            wait_done(0, 300, 1, $sformatf("rnd%0d_done_seen", f));
            check_frame_a($sformatf("rnd%0d", f), rows_a[0], rows_a[1]);
        end
        check("rnd_stable", 32'(unstable_a), 32'd0);

        // Reset in SAMPLE of row 1
        pix_ready_a = 1'b0;
        repeat (3) @(negedge clk);
        clear_logs();
        pulse_start(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_pre_reset", {read_en_a, row_sel_a, pix_valid_a}, {1'b1, 2'b10, 1'b1});
        reset = 1'b1;
        #1;
        check("mid_reset_async", {busy_a, read_en_a, row_sel_a, pix_valid_a, done_a}, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_no_done", 32'(done_cnt_a), 32'd0);
        rows_a[0] = 16'h6655; rows_a[1] = 16'h8877;
        pix_ready_a = 1'b1;
        clear_logs();
        pulse_start(0);
        wait_done(0, 50, 0, "mid_done_seen");
        check_frame_a("mid", 16'h6655, 16'h8877);

        check("sel_onehot", 32'(sel_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
